tdpsram_req_arb: RTL and testbench
==================================

TDPSRAM_REQ_ARB -- requirements
Module: tdpsram_req_arb

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
  DATA_WIDTH, 32, word width in bits
  DATA_DEPTH, 1024, word count; AW = $clog2(DATA_DEPTH)
  BYTE_SIZE, 32, write-enable granularity; NB = DATA_WIDTH/BYTE_SIZE
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning; c in {0,1}:
  clk  in  1  sole clock, rising edge
  rst_n  in  1  synchronous active-low reset
  req{c}_valid_i  in  1  request valid
  req{c}_ready_o  out  1  request accepted when valid&ready
  req{c}_addr_i  in  AW  word address
  req{c}_we_i  in  NB  byte-lane write enables; 0 = read
  req{c}_wdata_i  in  DATA_WIDTH  write data
  resp{c}_valid_o  out  1  response valid
  resp{c}_ready_i  in  1  response consumed when valid&ready
  resp{c}_rdata_o  out  DATA_WIDTH  read data (write-first for writes)
  addr{c}_o  out  AW  SRAM port c address
  en{c}_o  out  1  SRAM port c enable
  we{c}_o  out  NB  SRAM port c byte enables
  wdata{c}_o  out  DATA_WIDTH  SRAM port c write data
  rdata{c}_i  in  DATA_WIDTH  SRAM port c data, valid one cycle after en

Function
REQ-003 Each channel SHALL run a state machine: IDLE (no response pending), WAIT (access issued last cycle), HOLD (response stalled).
REQ-004 req{c}_ready_o SHALL be 1 when the channel is in IDLE, or in WAIT/HOLD with resp{c}_ready_i=1, and REQ-008 does not block it.
REQ-005 en{c}_o SHALL equal req{c}_valid_i & req{c}_ready_o; addr/we/wdata SHALL pass through combinationally.
REQ-006 On acceptance: next state WAIT; resp{c}_valid_o=1 exactly one cycle later; both reads and writes produce a response.
REQ-007 In WAIT, resp{c}_rdata_o SHALL be rdata{c}_i; if resp{c}_ready_i=0, capture rdata{c}_i into a hold register and go HOLD; HOLD drives the hold register; a response is consumed in WAIT or HOLD when resp{c}_ready_i=1, next state WAIT if a new request is accepted, else IDLE.
REQ-008 Same-address conflict (both channels eligible, both valid, equal addresses): channel 0 SHALL be issued; channel 1 SHALL have req1_ready_o=0 and en1_o=0 that cycle; it SHALL be retried the next cycle.
REQ-009 The SRAM SHALL never see en0_o & en1_o with addr0_o==addr1_o.
REQ-010 Back-to-back throughput SHALL be one request per cycle per channel while resp ready stays 1.

Reset
REQ-011 With rst_n=0 at a clk edge, both channels SHALL go IDLE; resp{c}_valid_o=0, req{c}_ready_o=0, en{c}_o=0 while rst_n=0; hold registers SHALL be cleared to 0.
REQ-012 Reset mid-operation SHALL drop pending responses without emitting them; req{c}_ready_o=1 in the first cycle after release.

Configuration
REQ-013 Macro TDPSRAM_REQ_READ_MERGE_EN defined: a REQ-008 conflict where both we are all-zero SHALL accept both; en1_o=0; channel 1 response data SHALL come from rdata0_i (and its hold register).
REQ-014 Macro undefined: every conflict SHALL stall channel 1 per REQ-008; conflicts involving any write always stall in both builds.

Verification
REQ-015 Reset, then ch0 write addr 5 data 0xDEADBEEF we=1 -> en0_o=1 that cycle; resp0_valid_o=1 next cycle with rdata 0xDEADBEEF.
REQ-016 ch0 read addr 5 with resp0_ready_i=0 for 3 cycles -> resp0 stays valid with 0xDEADBEEF; req0_ready_o=0 those cycles; released on ready=1.
REQ-017 Both channels write addr 7 same cycle (0x1, 0x2) -> ch0 issued, ch1 issued next cycle; final read of addr 7 returns 0x2.
REQ-018 Both channels read addr 5 same cycle -> merge build: both responses 0xDEADBEEF next cycle, en1_o=0; non-merge build: ch1 response one cycle later.
REQ-019 rst_n=0 while ch0 in HOLD -> resp0_valid_o=0 after the edge; no stale response after release.

Source files
------------

// File: rtl/tdpsram_req_arb.sv
`default_nettype none
// ============================================================================
// Module   : tdpsram_req_arb
// Purpose  : Two-channel request/response front end for a true-dual-port SRAM
//            with a one-cycle read latency. Each channel owns one SRAM port.
//            Every accepted request (read or write) produces exactly one
//            response. The response data is the SRAM output, which is
//            write-first for writes. A response stalled by the consumer is
//            parked in a per-channel hold register. Same-address collisions
//            between the channels are resolved in favour of channel 0, so the
//            SRAM never sees both ports enabled on one address.
//
// Optional feature (macro TDPSRAM_REQ_READ_MERGE_EN):
//            When both requests in a same-address collision are reads, both
//            are accepted together. Only SRAM port 0 is enabled, and channel 1
//            takes its response data from rdata0_i.
//            When the macro is undefined, every collision stalls channel 1.
//
// Ports    : clk, rst_n              clock, synchronous active-low reset
//            req{c}_*                request handshake, address, byte enables,
//                                    write data (c = 0, 1)
//            resp{c}_*               response handshake and read data
//            addr/en/we/wdata{c}_o   SRAM port c controls
//            rdata{c}_i              SRAM port c data, one cycle after en
//
// Revision : 1.0  initial release
// ============================================================================
module tdpsram_req_arb #(
    parameter int DATA_WIDTH = 32,
    parameter int DATA_DEPTH = 1024,
    parameter int BYTE_SIZE  = 32
) (
    input  logic                                clk,
    input  logic                                rst_n,

    input  logic                                req0_valid_i,
    output logic                                req0_ready_o,
    input  logic [$clog2(DATA_DEPTH)-1:0]       req0_addr_i,
    input  logic [DATA_WIDTH/BYTE_SIZE-1:0]     req0_we_i,
    input  logic [DATA_WIDTH-1:0]               req0_wdata_i,
    output logic                                resp0_valid_o,
    input  logic                                resp0_ready_i,
    output logic [DATA_WIDTH-1:0]               resp0_rdata_o,

    input  logic                                req1_valid_i,
    output logic                                req1_ready_o,
    input  logic [$clog2(DATA_DEPTH)-1:0]       req1_addr_i,
    input  logic [DATA_WIDTH/BYTE_SIZE-1:0]     req1_we_i,
    input  logic [DATA_WIDTH-1:0]               req1_wdata_i,
    output logic                                resp1_valid_o,
    input  logic                                resp1_ready_i,
    output logic [DATA_WIDTH-1:0]               resp1_rdata_o,

    output logic [$clog2(DATA_DEPTH)-1:0]       addr0_o,
    output logic                                en0_o,
    output logic [DATA_WIDTH/BYTE_SIZE-1:0]     we0_o,
    output logic [DATA_WIDTH-1:0]               wdata0_o,
    input  logic [DATA_WIDTH-1:0]               rdata0_i,

    output logic [$clog2(DATA_DEPTH)-1:0]       addr1_o,
    output logic                                en1_o,
    output logic [DATA_WIDTH/BYTE_SIZE-1:0]     we1_o,
    output logic [DATA_WIDTH-1:0]               wdata1_o,
    input  logic [DATA_WIDTH-1:0]               rdata1_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,   // no response pending
        S_WAIT = 2'd1,   // access issued last cycle, SRAM data on rdata
        S_HOLD = 2'd2    // response stalled, data parked in hold register
    } state_t;

    logic [1:0]            w_valid;
    logic [1:0]            w_resp_ready;
    logic [1:0]            w_busy;
    logic [1:0]            w_base_ready;
    logic [1:0]            w_ready;
    logic [1:0]            w_accept;
    logic                  w_conflict;
    logic                  w_merge;
    logic                  r_merge1;
    logic [DATA_WIDTH-1:0] w_src   [2];
    logic [DATA_WIDTH-1:0] w_rdata [2];

    assign w_valid      = {req1_valid_i, req0_valid_i};
    assign w_resp_ready = {resp1_ready_i, resp0_ready_i};

    // A channel may take a new request when nothing is pending, or when the
    // pending response leaves this very cycle. Reset forces it closed.
    // Both channels must be able to issue for a collision to exist.
    assign w_conflict = w_base_ready[0] && w_base_ready[1]
                     && req0_valid_i && req1_valid_i
                     && (req0_addr_i == req1_addr_i);

`ifdef TDPSRAM_REQ_READ_MERGE_EN
    // A read/read collision is served by a single SRAM port-0 access.
    assign w_merge = w_conflict && (req0_we_i == '0) && (req1_we_i == '0);
`else
    assign w_merge = 1'b0;
`endif

    assign w_ready[0]  = w_base_ready[0];
    assign w_ready[1]  = w_base_ready[1] && !(w_conflict && !w_merge);
    assign w_accept    = w_valid & w_ready;

    // Remembers that channel 1's outstanding access was merged onto port 0,
    // so its response data has to be taken from rdata0_i.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_merge1 <= 1'b0;
        end else if (w_accept[1]) begin
            r_merge1 <= w_merge;
        end
    end

    assign w_src[0] = rdata0_i;
    assign w_src[1] = r_merge1 ? rdata0_i : rdata1_i;

    for (genvar c = 0; c < 2; c++) begin : g_ch
        state_t                r_state;
        state_t                w_state_nxt;
        logic [DATA_WIDTH-1:0] r_hold;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_state <= S_IDLE;
            end else begin
                r_state <= w_state_nxt;
            end
        end

        // SRAM data is only valid in the cycle after the access, so a stalled
        // response must be captured on its way into HOLD.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_hold <= '0;
            end else if ((r_state == S_WAIT) && !w_resp_ready[c]) begin
                r_hold <= w_src[c];
            end
        end

        always_comb begin
            w_state_nxt = r_state;
            case (r_state)
                S_IDLE: begin
                    if (w_accept[c]) begin
                        w_state_nxt = S_WAIT;
                    end
                end
                S_WAIT, S_HOLD: begin
                    if (w_resp_ready[c]) begin
                        w_state_nxt = w_accept[c] ? S_WAIT : S_IDLE;
                    end else begin
                        w_state_nxt = S_HOLD;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end

        assign w_busy[c]       = (r_state != S_IDLE);
        assign w_base_ready[c] = rst_n && (!w_busy[c] || w_resp_ready[c]);
        assign w_rdata[c]      = (r_state == S_HOLD) ? r_hold : w_src[c];
    end

    assign req0_ready_o  = w_ready[0];
    assign req1_ready_o  = w_ready[1];
    assign resp0_valid_o = rst_n && w_busy[0];
    assign resp1_valid_o = rst_n && w_busy[1];
    assign resp0_rdata_o = w_rdata[0];
    assign resp1_rdata_o = w_rdata[1];

    assign en0_o    = w_accept[0];
    assign en1_o    = w_accept[1] && !w_merge;
    assign addr0_o  = req0_addr_i;
    assign we0_o    = req0_we_i;
    assign wdata0_o = req0_wdata_i;
    assign addr1_o  = req1_addr_i;
    assign we1_o    = req1_we_i;
    assign wdata1_o = req1_wdata_i;

endmodule
`default_nettype wire

// File: tb/tb_tdpsram_req_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_tdpsram_req_arb
// Purpose  : Self-checking bench for tdpsram_req_arb. A write-first SRAM with
//            one-cycle latency is attached to both ports. Expected response
//            data is pushed to a per-channel queue when a request is accepted
//            and is popped when the response is consumed. Handshake, enable
//            and pass-through outputs are compared every cycle on the falling
//            edge.
// Revision : 1.0  initial release
// ============================================================================
module tb_tdpsram_req_arb;

    localparam int DW    = 32;
    localparam int DEPTH = 1024;
    localparam int BS    = 32;
    localparam int AW    = $clog2(DEPTH);
    localparam int NB    = DW / BS;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [NB-1:0] we;
        logic [DW-1:0] wdata;
    } req_t;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;

    logic          req0_valid_i  = 1'b0;
    logic [AW-1:0] req0_addr_i   = '0;
    logic [NB-1:0] req0_we_i     = '0;
    logic [DW-1:0] req0_wdata_i  = '0;
    logic          resp0_ready_i = 1'b1;
    logic          req1_valid_i  = 1'b0;
    logic [AW-1:0] req1_addr_i   = '0;
    logic [NB-1:0] req1_we_i     = '0;
    logic [DW-1:0] req1_wdata_i  = '0;
    logic          resp1_ready_i = 1'b1;

    logic          req0_ready_o, resp0_valid_o, req1_ready_o, resp1_valid_o;
    logic [DW-1:0] resp0_rdata_o, resp1_rdata_o;
    logic [AW-1:0] addr0_o, addr1_o;
    logic          en0_o, en1_o;
    logic [NB-1:0] we0_o, we1_o;
    logic [DW-1:0] wdata0_o, wdata1_o;
    logic [DW-1:0] rdata0_i = '0;
    logic [DW-1:0] rdata1_i = '0;

    logic [DW-1:0] mem    [DEPTH] = '{default: '0};
    logic [DW-1:0] shadow [DEPTH] = '{default: '0};

    req_t          stim_q [2][$];
    logic [DW-1:0] exp_q  [2][$];
    logic [1:0]    m_rv    = 2'b00;
    logic [1:0]    rr_val  = 2'b11;
    bit            rand_rr = 1'b0;
    int            n_chk   = 0;
    int            n_err   = 0;
    int            acc_cnt = 0;

    always #5 clk = ~clk;

    tdpsram_req_arb #(
        .DATA_WIDTH (DW),
        .DATA_DEPTH (DEPTH),
        .BYTE_SIZE  (BS)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req0_valid_i  (req0_valid_i),
        .req0_ready_o  (req0_ready_o),
        .req0_addr_i   (req0_addr_i),
        .req0_we_i     (req0_we_i),
        .req0_wdata_i  (req0_wdata_i),
        .resp0_valid_o (resp0_valid_o),
        .resp0_ready_i (resp0_ready_i),
        .resp0_rdata_o (resp0_rdata_o),
        .req1_valid_i  (req1_valid_i),
        .req1_ready_o  (req1_ready_o),
        .req1_addr_i   (req1_addr_i),
        .req1_we_i     (req1_we_i),
        .req1_wdata_i  (req1_wdata_i),
        .resp1_valid_o (resp1_valid_o),
        .resp1_ready_i (resp1_ready_i),
        .resp1_rdata_o (resp1_rdata_o),
        .addr0_o       (addr0_o),
        .en0_o         (en0_o),
        .we0_o         (we0_o),
        .wdata0_o      (wdata0_o),
        .rdata0_i      (rdata0_i),
        .addr1_o       (addr1_o),
        .en1_o         (en1_o),
        .we1_o         (we1_o),
        .wdata1_o      (wdata1_o),
        .rdata1_i      (rdata1_i)
    );

    function automatic logic [DW-1:0] lane_merge(input logic [DW-1:0] old,
                                                 input logic [DW-1:0] wd,
                                                 input logic [NB-1:0] we);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < NB; b++) begin
            if (we[b]) r[b*BS +: BS] = wd[b*BS +: BS];
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Write-first dual-port SRAM, one-cycle read latency.
    always @(posedge clk) begin
        if (en0_o) begin
            if (we0_o != '0) mem[addr0_o] <= lane_merge(mem[addr0_o], wdata0_o, we0_o);
            rdata0_i <= lane_merge(mem[addr0_o], wdata0_o, we0_o);
        end
        if (en1_o) begin
            if (we1_o != '0) mem[addr1_o] <= lane_merge(mem[addr1_o], wdata1_o, we1_o);
            rdata1_i <= lane_merge(mem[addr1_o], wdata1_o, we1_o);
        end
    end

    // Request driver: holds each request stable until it is taken.
    always begin
        bit   took0, took1;
        req_t r;
        @(negedge clk);
        took0 = req0_valid_i && req0_ready_o;
        took1 = req1_valid_i && req1_ready_o;
        @(posedge clk);
        #2;
        if (took0) req0_valid_i = 1'b0;
        if (took1) req1_valid_i = 1'b0;
        if (!req0_valid_i && stim_q[0].size() > 0) begin
            r = stim_q[0].pop_front();
            req0_valid_i = 1'b1; req0_addr_i = r.addr; req0_we_i = r.we; req0_wdata_i = r.wdata;
        end
        if (!req1_valid_i && stim_q[1].size() > 0) begin
            r = stim_q[1].pop_front();
            req1_valid_i = 1'b1; req1_addr_i = r.addr; req1_we_i = r.we; req1_wdata_i = r.wdata;
        end
        if (rand_rr) begin
            resp0_ready_i = ($urandom % 4) != 0;
            resp1_ready_i = ($urandom % 4) != 0;
        end else begin
            resp0_ready_i = rr_val[0];
            resp1_ready_i = rr_val[1];
        end
    end

    // Cycle monitor and scoreboard.
    always @(negedge clk) begin
        logic          b0, b1, cf, mg, r0, r1, a0, a1;
        logic [1:0]    rr, acc;
        logic [DW-1:0] rd [2];
        logic [DW-1:0] nv;
        rr    = {resp1_ready_i, resp0_ready_i};
        rd[0] = resp0_rdata_o;
        rd[1] = resp1_rdata_o;
        b0 = rst_n && (!m_rv[0] || rr[0]);
        b1 = rst_n && (!m_rv[1] || rr[1]);
        cf = b0 && b1 && req0_valid_i && req1_valid_i && (req0_addr_i == req1_addr_i);
        mg = 1'b0;
`ifdef TDPSRAM_REQ_READ_MERGE_EN
        mg = cf && (req0_we_i == '0) && (req1_we_i == '0);
`endif
        r0 = b0;
        r1 = b1 && !(cf && !mg);
        a0 = req0_valid_i && r0;
        a1 = req1_valid_i && r1;
        acc = {a1, a0};

        check("req0_ready", req0_ready_o, r0);
        check("req1_ready", req1_ready_o, r1);
        check("en0", en0_o, a0);
        check("en1", en1_o, a1 && !mg);
        check("resp0_valid", resp0_valid_o, m_rv[0] && rst_n);
        check("resp1_valid", resp1_valid_o, m_rv[1] && rst_n);
        check("addr0_pass", addr0_o, req0_addr_i);
        check("addr1_pass", addr1_o, req1_addr_i);
        check("we0_pass", we0_o, req0_we_i);
        check("we1_pass", we1_o, req1_we_i);
        check("wdata0_pass", wdata0_o, req0_wdata_i);
        check("wdata1_pass", wdata1_o, req1_wdata_i);
        check("sram_collide", en0_o && en1_o && (addr0_o == addr1_o), 1'b0);

        if (!rst_n) begin
            exp_q[0].delete();
            exp_q[1].delete();
            m_rv = 2'b00;
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (m_rv[c] && rr[c]) begin
                    if (exp_q[c].size() == 0) check(c ? "sb_under1" : "sb_under0", 1, 0);
                    else check(c ? "rdata1" : "rdata0", rd[c], exp_q[c].pop_front());
                end
            end
            if (a0) begin
                nv = lane_merge(shadow[req0_addr_i], req0_wdata_i, req0_we_i);
                shadow[req0_addr_i] = nv;
                exp_q[0].push_back(nv);
                acc_cnt++;
            end
            if (a1) begin
                nv = lane_merge(shadow[req1_addr_i], req1_wdata_i, req1_we_i);
                shadow[req1_addr_i] = nv;
                exp_q[1].push_back(nv);
                acc_cnt++;
            end
            for (int c = 0; c < 2; c++) begin
                if (acc[c]) m_rv[c] = 1'b1;
                else if (m_rv[c] && rr[c]) m_rv[c] = 1'b0;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int c, input int addr, input int we, input logic [DW-1:0] wd);
        req_t r;
        r.addr  = AW'(addr);
        r.we    = NB'(we);
        r.wdata = wd;
        stim_q[c].push_back(r);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            step(1);
            if (stim_q[0].size() == 0 && stim_q[1].size() == 0 && !req0_valid_i
                && !req1_valid_i && m_rv == 2'b00 && exp_q[0].size() == 0
                && exp_q[1].size() == 0) return;
        end
        check("idle_timeout", 0, 1);
    endtask

    initial begin
        int c0;
        step(3);
        rst_n = 1'b1;
        step(1);

        // Write then stalled read of address 5.
        push(0, 5, 1, 32'hDEAD_BEEF);
        wait_idle();
        rr_val[0] = 1'b0;
        push(0, 5, 0, 32'h0);
        step(4);
        check("hold_valid", resp0_valid_o, 1'b1);
        check("hold_data", resp0_rdata_o, 32'hDEAD_BEEF);
        rr_val[0] = 1'b1;
        wait_idle();

        // Same-address writes, then read back; same-address reads.
        push(0, 7, 1, 32'h1);
        push(1, 7, 1, 32'h2);
        wait_idle();
        push(0, 7, 0, 32'h0);
        wait_idle();
        push(0, 5, 0, 32'h0);
        push(1, 5, 0, 32'h0);
        wait_idle();

        // Back-to-back throughput on both channels.
        c0 = acc_cnt;
        for (int i = 0; i < 8; i++) begin
            push(0, 100 + i, i % 2, 32'(i * 3 + 1));
            push(1, 200 + i, (i + 1) % 2, 32'(i * 5 + 2));
        end
        repeat (8) @(negedge clk);
        @(posedge clk);
        #1;
        check("throughput", acc_cnt - c0, 16);
        wait_idle();

        // Random traffic with heavy address collisions and stalls.
        rand_rr = 1'b1;
        for (int i = 0; i < 300; i++) begin
            step(1);
            for (int c = 0; c < 2; c++) begin
                if (stim_q[c].size() == 0 && ($urandom % 2) == 0)
                    push(c, $urandom % 4, $urandom % 2, $urandom);
            end
        end
        rand_rr = 1'b0;
        rr_val  = 2'b11;
        wait_idle();

        // Reset while channel 0 is holding a response.
        rr_val[0] = 1'b0;
        push(0, 5, 0, 32'h0);
        step(3);
        check("pre_rst_hold", resp0_valid_o, 1'b1);
        rst_n = 1'b0;
        step(2);
        check("rst_valid", resp0_valid_o, 1'b0);
        rr_val[0] = 1'b1;
        rst_n = 1'b1;
        step(3);
        check("no_stale", resp0_valid_o, 1'b0);
        push(0, 7, 0, 32'h0);
        wait_idle();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
